// File: rtl/apb_bridge_mux_pkg.sv
// Shared types and default sizing for the APB bridge/decoder and its helpers.
// No logic: constants, state enum and slave-index type only.
package apb_bridge_mux_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUS_WIDTH_DEF  = 32;
    localparam int SEL_BITS_DEF   = 2;
    localparam int STRB_WIDTH     = BUS_WIDTH_DEF / DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef logic [SEL_BITS_DEF-1:0] slv_idx_t;

    function automatic int strb_width(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: counts enabled cycles since clear; expired_o is combinational, 0 latency.
// LIMIT=0 never expires; no backpressure, the owner decides when to clear.
module apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the LIMIT-th stalled cycle so the bridge leaves ACCESS after exactly LIMIT cycles.
    assign expired_o = (LIMIT > 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_bridge_mux.sv
// APB 1-to-N bridge: decode top address bits, re-time the request, return pready T+3 (zero-wait) or T+1 (decode error).
// Upstream is stalled by withholding up_pready; downstream wait states and timeouts extend the stall.
module apb_bridge_mux
    import apb_bridge_mux_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_BITS       = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             up_psel,
    input  logic                             up_penable,
    input  logic                             up_pwrite,
    input  logic [BUS_WIDTH/DATA_WIDTH-1:0]  up_pstrb,
    input  logic [ADDR_WIDTH-1:0]            up_paddr,
    input  logic [BUS_WIDTH-1:0]             up_pwdata,
    output logic [BUS_WIDTH-1:0]             up_prdata,
    output logic                             up_pready,
    output logic                             up_pslverr,
    output logic                             busy,
    output logic [NUM_SLAVES-1:0]            dn_psel,
    output logic                             dn_penable,
    output logic                             dn_pwrite,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0]  dn_pstrb,
    output logic [ADDR_WIDTH-1:0]            dn_paddr,
    output logic [BUS_WIDTH-1:0]             dn_pwdata,
    input  logic [NUM_SLAVES*BUS_WIDTH-1:0]  dn_prdata,
    input  logic [NUM_SLAVES-1:0]            dn_pready,
    input  logic [NUM_SLAVES-1:0]            dn_pslverr,
    input  logic [NUM_SLAVES-1:0]            dn_busy
);
    localparam int STRB_W = BUS_WIDTH / DATA_WIDTH;

    apb_state_e            state_q, state_d;
    logic [SEL_BITS-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  drop_q, drop_d;

    logic [SEL_BITS-1:0]   up_idx;
    logic                  up_idx_ok;
    logic                  sel_rdy, sel_err;
    logic [BUS_WIDTH-1:0]  sel_rdata;
    logic                  dn_active;
    logic                  tmo_expired;
    logic                  unused_penable;

    assign unused_penable = up_penable;

    assign up_idx    = up_paddr[ADDR_WIDTH-1 -: SEL_BITS];
    assign up_idx_ok = (int'(up_idx) < NUM_SLAVES);

    // Only the addressed slave's response is visible; others are ignored.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_BITS'(i)) begin
                sel_rdy   = dn_pready[i];
                sel_err   = dn_pslverr[i];
                sel_rdata = dn_prdata[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_SETUP),
        .en_i      ((state_q == ST_ACCESS) && !sel_rdy),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        drop_d  = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (up_psel) begin
                    idx_d   = up_idx;
                    addr_d  = up_paddr;
                    wdata_d = up_pwdata;
                    strb_d  = up_pstrb;
                    write_d = up_pwrite;
                    rdata_d = '0;
                    drop_d  = 1'b0;
                    err_d   = !up_idx_ok;
                    state_d = up_idx_ok ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP: begin
                if (!up_psel) drop_d = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A master that abandons the transfer still lets the slave finish; only the reply is suppressed.
                if (!up_psel) drop_d = 1'b1;
                if (sel_rdy) begin
                    rdata_d = sel_rdata;
                    err_d   = sel_err;
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            drop_q  <= drop_d;
        end
    end

    assign dn_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

    always_comb begin
        dn_psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dn_psel[i] = dn_active && (idx_q == SEL_BITS'(i));
        end
    end

    assign dn_penable = (state_q == ST_ACCESS);
    assign dn_pwrite  = write_q;
    assign dn_pstrb   = strb_q;
    assign dn_paddr   = addr_q;
    assign dn_pwdata  = wdata_q;

    assign up_pready  = (state_q == ST_RESP) && !drop_q;
    assign up_pslverr = up_pready && err_q;
    assign up_prdata  = (up_pready && !write_q && !err_q) ? rdata_q : '0;

    assign busy = |dn_busy;

endmodule

// File: tb/tb_apb_bridge_mux.sv
// Directed bench for apb_bridge_mux: 4-slave instance for traffic, 3-slave instance for decode errors.
module tb_apb_bridge_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         up_psel, up_psel3, up_penable, up_pwrite;
    logic [3:0]   up_pstrb;
    logic [15:0]  up_paddr;
    logic [31:0]  up_pwdata;
    logic [31:0]  up_prdata, up_prdata3;
    logic         up_pready, up_pready3, up_pslverr, up_pslverr3, busy, busy3;
    logic [3:0]   dn_psel;
    logic [2:0]   dn_psel3;
    logic         dn_penable, dn_penable3, dn_pwrite, dn_pwrite3;
    logic [3:0]   dn_pstrb, dn_pstrb3;
    logic [15:0]  dn_paddr, dn_paddr3;
    logic [31:0]  dn_pwdata, dn_pwdata3;
    logic [127:0] dn_prdata;
    logic [95:0]  dn_prdata3;
    logic [3:0]   dn_pready = '0, dn_pslverr, dn_busy;
    logic [2:0]   dn_pready3, dn_pslverr3, dn_busy3;

    int n_chk = 0;
    int n_bad = 0;
    int wait_st [4];
    int acc [4];
    logic [3:0] psel_hist [65];

    always #5 clk = ~clk;

    apb_bridge_mux u_dut (
        .clk(clk), .rst_n(rst_n),
        .up_psel(up_psel), .up_penable(up_penable), .up_pwrite(up_pwrite),
        .up_pstrb(up_pstrb), .up_paddr(up_paddr), .up_pwdata(up_pwdata),
        .up_prdata(up_prdata), .up_pready(up_pready), .up_pslverr(up_pslverr),
        .busy(busy), .dn_psel(dn_psel), .dn_penable(dn_penable), .dn_pwrite(dn_pwrite),
        .dn_pstrb(dn_pstrb), .dn_paddr(dn_paddr), .dn_pwdata(dn_pwdata),
        .dn_prdata(dn_prdata), .dn_pready(dn_pready), .dn_pslverr(dn_pslverr),
        .dn_busy(dn_busy)
    );

    apb_bridge_mux #(.NUM_SLAVES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .up_psel(up_psel3), .up_penable(up_penable), .up_pwrite(up_pwrite),
        .up_pstrb(up_pstrb), .up_paddr(up_paddr), .up_pwdata(up_pwdata),
        .up_prdata(up_prdata3), .up_pready(up_pready3), .up_pslverr(up_pslverr3),
        .busy(busy3), .dn_psel(dn_psel3), .dn_penable(dn_penable3), .dn_pwrite(dn_pwrite3),
        .dn_pstrb(dn_pstrb3), .dn_paddr(dn_paddr3), .dn_pwdata(dn_pwdata3),
        .dn_prdata(dn_prdata3), .dn_pready(dn_pready3), .dn_pslverr(dn_pslverr3),
        .dn_busy(dn_busy3)
    );

    // Slave model: ready after wait_st[i] stalled ACCESS cycles; large wait_st means never.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (dn_psel[i] && dn_penable) begin
                dn_pready[i] = (acc[i] >= wait_st[i]);
                acc[i]++;
            end else begin
                dn_pready[i] = 1'b0;
                acc[i] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one upstream transfer; rcyc is the cycle offset of up_pready from setup (-1 on no reply).
    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output int rcyc, output logic [31:0] rd,
                        output logic er, output logic [31:0] pwd1, output logic rdy_next);
        @(negedge clk);
        up_psel = 1'b1; up_penable = 1'b0; up_pwrite = wr;
        up_paddr = a; up_pwdata = wd; up_pstrb = st;
        rcyc = -1; rd = '0; er = 1'b0; pwd1 = '0;
        for (int c = 0; c < 65; c++) psel_hist[c] = '0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            psel_hist[c] = dn_psel;
            if (c == 1) pwd1 = dn_pwdata;
            up_penable = 1'b1;
            if (up_pready) begin
                rcyc = c; rd = up_prdata; er = up_pslverr;
                break;
            end
        end
        if (rcyc < 0) chk("xfer_timeout", 1'b1, 1'b0);
        up_psel = 1'b0; up_penable = 1'b0;
        @(negedge clk);
        rdy_next = up_pready;
    endtask

    int          rcyc;
    logic [31:0] rd, pwd1;
    logic        er, rdy_next, seen_rdy;

    initial begin
        rst_n = 1'b0;
        up_psel = 0; up_psel3 = 0; up_penable = 0; up_pwrite = 0;
        up_pstrb = '0; up_paddr = '0; up_pwdata = '0;
        dn_pslverr = '0; dn_busy = '0;
        dn_pready3 = 3'b111; dn_pslverr3 = '0; dn_busy3 = '0;
        dn_prdata3 = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
        dn_prdata = {32'h3333_3333, 32'hCAFE_F00D, 32'h1234_5678, 32'h0BAD_0BAD};
        for (int i = 0; i < 4; i++) begin wait_st[i] = 0; acc[i] = 0; end

        repeat (2) @(negedge clk);
        chk("rst_pready", up_pready, 1'b0);
        chk("rst_psel", dn_psel, 4'b0000);
        chk("rst_penable", dn_penable, 1'b0);
        chk("rst_paddr", dn_paddr, 16'h0000);
        chk("rst_prdata", up_prdata, 32'h0);
        rst_n = 1'b1;

        // zero-wait write to slave 2
        xfer(1'b1, 16'h8004, 32'hDEAD_BEEF, 4'b1111, rcyc, rd, er, pwd1, rdy_next);
        chk("wr_psel_t1", psel_hist[1], 4'b0100);
        chk("wr_pwdata", pwd1, 32'hDEAD_BEEF);
        chk("wr_lat", rcyc, 3);
        chk("wr_err", er, 1'b0);
        chk("wr_prdata", rd, 32'h0);
        chk("wr_ready_1cyc", rdy_next, 1'b0);

        // 3-wait-state read from slave 1
        wait_st[1] = 3;
        xfer(1'b0, 16'h4010, 32'h0, 4'b0000, rcyc, rd, er, pwd1, rdy_next);
        chk("rd_psel_t1", psel_hist[1], 4'b0010);
        chk("rd_lat", rcyc, 6);
        chk("rd_data", rd, 32'h1234_5678);
        chk("rd_err", er, 1'b0);
        chk("rd_ready_1cyc", rdy_next, 1'b0);

        // decode error on the 3-slave instance
        @(negedge clk);
        up_psel3 = 1'b1; up_pwrite = 1'b0; up_paddr = 16'hC000;
        @(negedge clk);
        chk("dec_pready", up_pready3, 1'b1);
        chk("dec_pslverr", up_pslverr3, 1'b1);
        chk("dec_prdata", up_prdata3, 32'h0);
        chk("dec_psel", dn_psel3, 3'b000);
        up_psel3 = 1'b0;
        @(negedge clk);
        chk("dec_ready_1cyc", up_pready3, 1'b0);
        chk("dec_psel_after", dn_psel3, 3'b000);

        // timeout on slave 0, then a normal transfer to slave 1
        wait_st[0] = 1000;
        xfer(1'b0, 16'h0000, 32'h0, 4'b0000, rcyc, rd, er, pwd1, rdy_next);
        chk("tmo_psel_last", psel_hist[17], 4'b0001);
        chk("tmo_psel_drop", psel_hist[18], 4'b0000);
        chk("tmo_lat", rcyc, 18);
        chk("tmo_err", er, 1'b1);
        chk("tmo_prdata", rd, 32'h0);
        xfer(1'b1, 16'h4020, 32'h5555_AAAA, 4'b0011, rcyc, rd, er, pwd1, rdy_next);
        chk("post_tmo_lat", rcyc, 6);
        chk("post_tmo_err", er, 1'b0);

        // busy aggregation is combinational
        @(negedge clk);
        dn_busy = 4'b0010; dn_busy3 = 3'b100;
        #1;
        chk("busy_on", busy, 1'b1);
        chk("busy3_on", busy3, 1'b1);
        dn_busy = 4'b0000; dn_busy3 = 3'b000;
        #1;
        chk("busy_off", busy, 1'b0);
        chk("busy3_off", busy3, 1'b0);

        // upstream abandons the transfer: slave still finishes, no reply
        wait_st[2] = 2;
        @(negedge clk);
        up_psel = 1'b1; up_pwrite = 1'b1; up_paddr = 16'h8000; up_pwdata = 32'h0F0F_0F0F;
        @(negedge clk);
        up_psel = 1'b0;
        seen_rdy = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) chk("drop_psel_kept", dn_psel, 4'b0100);
            if (up_pready) seen_rdy = 1'b1;
        end
        chk("drop_no_ready", seen_rdy, 1'b0);
        chk("drop_idle_psel", dn_psel, 4'b0000);

        // reset during ACCESS on slave 3
        wait_st[3] = 1000;
        @(negedge clk);
        up_psel = 1'b1; up_penable = 1'b0; up_pwrite = 1'b1; up_paddr = 16'hC004;
        up_pwdata = 32'h7777_1111; up_pstrb = 4'b1111;
        @(negedge clk);
        up_penable = 1'b1;
        @(negedge clk);
        chk("rst_mid_access", {dn_psel, dn_penable}, {4'b1000, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", dn_psel, 4'b0000);
        chk("rst_mid_penable", dn_penable, 1'b0);
        chk("rst_mid_pwdata", dn_pwdata, 32'h0);
        chk("rst_mid_pready", up_pready, 1'b0);
        up_psel = 1'b0; up_penable = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_resp", up_pready, 1'b0);
        rst_n = 1'b1;
        wait_st[3] = 0;
        xfer(1'b1, 16'hC008, 32'h2468_ACE0, 4'b1111, rcyc, rd, er, pwd1, rdy_next);
        chk("post_rst_lat", rcyc, 3);
        chk("post_rst_psel", psel_hist[1], 4'b1000);
        chk("post_rst_err", er, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
